// File: rtl/inst_fetcher_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : inst_fetcher_pkg                                             |
// | Description : Shared fetch-stage definitions: FSM state encoding, default  |
// |               datapath width and reset PC, and RV32I opcode constants      |
// |               that the decoder also relies on.                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package inst_fetcher_pkg;

  localparam int              DEF_XLEN     = 32;
  localparam logic [31:0]     DEF_RESET_PC = 32'h0000_0000;

  // Fetch FSM states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    ISSUE = 3'd2,
    STALL = 3'd3,
    DRAIN = 3'd4
  } if_state_e;

  // Major opcodes the decoder inspects to compute next PC / stall
  localparam logic [6:0] OPBRANCH = 7'b1100011;
  localparam logic [6:0] OPJAL    = 7'b1101111;
  localparam logic [6:0] OPJALR   = 7'b1100111;
  localparam logic [6:0] OPAUIPC  = 7'b0010111;

  function automatic logic [6:0] opcode_of(input logic [31:0] inst);
    return inst[6:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_fetcher_perf_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : if_perf_counter                                              |
// | Description : Saturating event counter used for fetch statistics.          |
// |   clk_i   - clock                                                          |
// |   rst_i   - synchronous active-high reset, clears the count                |
// |   en_i    - global enable; count frozen when low                           |
// |   inc_i   - event strobe                                                   |
// |   count_o - current count, sticks at all-ones                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module if_perf_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en_i && inc_i && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/inst_fetcher.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : inst_fetcher                                                 |
// | Description : Front-end PC owner. Issues one word fetch at a time to the   |
// |               I-cache, presents the returned word and its PC to the        |
// |               decoder / instruction queue, follows the decoder's next-PC,  |
// |               parks on JALR stalls and honours ROB redirects, squashing an |
// |               in-flight cache response when needed.                        |
// | Ports       : clk_in/rst_in/rdy_in - clock, sync reset, global freeze      |
// |               _icache_req/_icache_addr - level-held fetch request          |
// |               _icache_valid/_icache_data - one-cycle response              |
// |               _inst_out/_inst_addr_out/_inst_ready_out - decoder push      |
// |               _clear_out - flush to decoder (mirrors _br_rob)              |
// |               _next_pc_in/_stall_in - decoder next-PC and JALR stall       |
// |               _br_rob - ROB redirect, _iq_full - queue backpressure        |
// | Option      : IF_PERF_CNT_EN adds _perf_fetched / _perf_squashed counters  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter int              XLEN     = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            rdy_in,
  output logic            _icache_req,
  output logic [XLEN-1:0] _icache_addr,
  input  logic            _icache_valid,
  input  logic [XLEN-1:0] _icache_data,
  output logic [XLEN-1:0] _inst_out,
  output logic [XLEN-1:0] _inst_addr_out,
  output logic            _inst_ready_out,
  output logic            _clear_out,
  input  logic [XLEN-1:0] _next_pc_in,
  input  logic            _stall_in,
  input  logic            _br_rob,
  input  logic            _iq_full
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]     _perf_fetched,
  output logic [31:0]     _perf_squashed
`endif
);

  if_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q,    pc_d;
  logic            req_q,   req_d;
  logic [XLEN-1:0] addr_q,  addr_d;
  logic [XLEN-1:0] inst_q,  inst_d;
  logic [XLEN-1:0] iaddr_q, iaddr_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = req_q;
    addr_d  = addr_q;
    inst_d  = inst_q;
    iaddr_d = iaddr_q;

    unique case (state_q)
      IDLE: begin
        if (_br_rob) begin
          pc_d = _next_pc_in;
        end else if (!_iq_full) begin
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = FETCH;
        end
      end

      FETCH: begin
        if (_br_rob) begin
          pc_d  = _next_pc_in;
          req_d = 1'b0;
          // A response arriving with the redirect is simply dropped; otherwise
          // the cache still owes us one word that must be swallowed.
          state_d = _icache_valid ? IDLE : DRAIN;
        end else if (_icache_valid) begin
          inst_d  = _icache_data;
          iaddr_d = pc_q;
          req_d   = 1'b0;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        // With _br_rob the input already carries the ROB target.
        pc_d    = _next_pc_in;
        state_d = (!_br_rob && _stall_in) ? STALL : IDLE;
      end

      STALL: begin
        if (_br_rob) begin
          pc_d    = _next_pc_in;
          state_d = IDLE;
        end
      end

      DRAIN: begin
        if (_br_rob) begin
          pc_d = _next_pc_in;
        end
        // The owed response always ends the drain; waiting past it would
        // deadlock because the cache never sends a second one.
        if (_icache_valid) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      inst_q  <= '0;
      iaddr_q <= '0;
    end else if (rdy_in) begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      inst_q  <= inst_d;
      iaddr_q <= iaddr_d;
    end
  end

  assign _icache_req    = req_q;
  assign _icache_addr   = addr_q;
  assign _inst_out      = inst_q;
  assign _inst_addr_out = iaddr_q;
  assign _inst_ready_out = (state_q == ISSUE) && !_br_rob;
  assign _clear_out     = _br_rob;

`ifdef IF_PERF_CNT_EN
  logic w_squash_evt;

  assign w_squash_evt = _icache_valid &&
                        ((state_q == DRAIN) || ((state_q == FETCH) && _br_rob));

  if_perf_counter #(.WIDTH(32)) u_cnt_fetched (
    .clk_i   (clk_in),
    .rst_i   (rst_in),
    .en_i    (rdy_in),
    .inc_i   (_inst_ready_out),
    .count_o (_perf_fetched)
  );

  if_perf_counter #(.WIDTH(32)) u_cnt_squashed (
    .clk_i   (clk_in),
    .rst_i   (rst_in),
    .en_i    (rdy_in),
    .inc_i   (w_squash_evt),
    .count_o (_perf_squashed)
  );
`endif

endmodule
`default_nettype wire
